key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
// - Conditions raw board push-buttons before counters, FSMs and LED logic use them.
// - Per key: 2-FF synchroniser, then a debounce counter, then an auto-repeat FSM.
// - Outputs per key: a clean level plus single-cycle press, release and repeat pulses.
// - Sits directly upstream of the key-controlled counter labs and replaces ad-hoc key_r edge detectors.
// PARAMETERS
// - N_KEYS          2           number of independent keys
// - KEY_ACTIVE_LOW  1           1: key_in low = pressed (board default); 0: high = pressed
// - DEBOUNCE_CYCLES 500_000     consecutive cycles of a new level required to accept it (10 ms @ 50 MHz); >= 1
// - REPEAT_DELAY    25_000_000  cycles from press pulse to first repeat pulse (0.5 s); >= 1
// - REPEAT_PERIOD   5_000_000   cycles between later repeat pulses (0.1 s); >= 1
// PORTS
// - clk          in   1       system clock
// - reset_n      in   1       asynchronous, active-low reset
// - key_in       in   N_KEYS  raw asynchronous key pins
// - repeat_en    in   1       enables auto-repeat for all keys
// - key_down     out  N_KEYS  debounced level, 1 = pressed
// - key_press    out  N_KEYS  1-cycle pulse on accepted press
// - key_release  out  N_KEYS  1-cycle pulse on accepted release
// - key_repeat   out  N_KEYS  1-cycle pulse per auto-repeat
// BEHAVIOUR
// - Reset (async assert, sync-safe release):
//   - all outputs 0;
//   - sync FFs load the *released* pin level (1 if KEY_ACTIVE_LOW);
//   - counters 0; FSM IDLE.
// - Sync: sync = polarity-normalised key_in delayed by 2 FFs.
// - Debounce, per key:
//   - cnt is cleared while sync == key_down;
//   - otherwise cnt increments;
//   - when cnt == DEBOUNCE_CYCLES-1 and sync != key_down: key_down toggles on the next edge and cnt clears.
// - Debounce latency: a change held from capture edge 1 appears on key_down after edge DEBOUNCE_CYCLES+2.
//   - Any bounce back restarts the count.
//   - No pulse is produced for glitches shorter than DEBOUNCE_CYCLES.
// - Edge pulses:
//   - key_press is registered and high for exactly the one cycle key_down first reads 1.
//   - key_release is the same for key_down falling.
// - Repeat FSM (per key), states IDLE / HOLD / REPEAT, rpt_cnt width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
//   - IDLE   -> HOLD on press; rpt_cnt = 0.
//   - HOLD   -> REPEAT when rpt_cnt reaches REPEAT_DELAY-1; emit key_repeat; rpt_cnt = 0.
//   - REPEAT -> REPEAT when rpt_cnt reaches REPEAT_PERIOD-1; emit key_repeat; rpt_cnt = 0.
//   - Any state -> IDLE on release, same edge as key_release. No repeat pulse on that edge, even if the count expires.
//   - First key_repeat comes exactly REPEAT_DELAY cycles after key_press; later ones every REPEAT_PERIOD cycles.
// - repeat_en = 0:
//   - FSM holds HOLD or IDLE, rpt_cnt is forced to 0 and key_repeat stays 0.
//   - Re-enabling while held restarts the full REPEAT_DELAY.
// - Keys are fully independent; simultaneous events on several keys pulse in the same cycle.
// - key_press and key_repeat never coincide on the same key.
// STRUCTURE
// - Package key_debouncer_pkg holds:
//   - typedef enum logic [1:0] {IDLE, HOLD, REPEAT} key_rpt_state_t;
//   - function for the counter width.
// - Sub-module key_debounce_one: one key (sync + debounce + pulses + repeat FSM).
// - Top instantiates N_KEYS copies in a generate loop and shares repeat_en.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=2, active-low)
// - Reset, key_in=2'b11, 20 cycles -> all outputs 0, no pulses.
// - key_in[0] low, held -> key_down[0]=1 after edge 6; key_press[0] high for 1 cycle; key 1 untouched.
// - key_in[0] low 3 cycles, high 1, low 3, high -> no key_down, no press; key_release never pulses.
// - Hold key 0 with repeat_en=1 -> key_repeat[0] at press+10, +13, +16.
//   - Release -> key_release after 6 edges; repeats stop.
// - Both keys pressed on the same edge -> both key_press bits pulse in the same cycle.
//   - Key 1 released while key 0 repeats -> key 0 repeat cadence unchanged.
// - reset_n low mid-REPEAT with key held -> outputs 0 immediately.
//   - After reset_n rises -> key_press re-fires after 6 edges.
//   - With repeat_en=0: no key_repeat for 50 cycles.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// rtl/key_debouncer_pkg.sv - shared types and width helpers for the key debouncer
package key_debouncer_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} key_rpt_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// rtl/key_debouncer_if.sv - key pins, repeat enable and conditioned key outputs
interface key_debouncer_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_in;
  logic              repeat_en;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_in, repeat_en,
    input  key_down, key_press, key_release, key_repeat
  );

  modport slave (
    input  key_in, repeat_en,
    output key_down, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/key_debounce_one.sv
// rtl/key_debounce_one.sv - one key: synchroniser, debounce counter, edge pulses, auto-repeat
module key_debounce_one
  import key_debouncer_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_down,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam logic REL_LEVEL = KEY_ACTIVE_LOW;
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic           sync1, sync2, sync;
  logic [DW-1:0]  deb_cnt;
  logic           accept, rise, fall;
  key_rpt_state_t state, state_next;
  logic [RW-1:0]  rpt_cnt, rpt_cnt_next;
  logic           rpt_fire;

  // Pressed = 1 after removing the board polarity.
  assign sync   = sync2 ^ REL_LEVEL;
  assign accept = (sync != key_down) && (deb_cnt == DEB_LAST);
  assign rise   = accept && !key_down;
  assign fall   = accept && key_down;

  // Two-flop synchroniser; reset loads the released pin level so no false press after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= REL_LEVEL;
      sync2 <= REL_LEVEL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level must persist for DEBOUNCE_CYCLES before key_down follows it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt     <= '0;
      key_down    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= rise;
      key_release <= fall;
      if (sync == key_down || accept) deb_cnt <= '0;
      else                            deb_cnt <= deb_cnt + DW'(1);
      if (accept) key_down <= ~key_down;
    end
  end

  // Repeat FSM state, delay counter and registered repeat pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rpt_cnt    <= '0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_next;
      rpt_cnt    <= rpt_cnt_next;
      key_repeat <= rpt_fire;
    end
  end

  // Next state: release wins over any expiring count; disabling repeat parks the key in HOLD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = HOLD;
      HOLD:    if (fall) state_next = IDLE;
               else if (repeat_en && rpt_cnt == DLY_LAST) state_next = REPEAT;
      REPEAT:  if (fall) state_next = IDLE;
               else if (!repeat_en) state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

  // Repeat pulse and counter update; counter sits at 0 whenever repeat cannot run.
  always_comb begin
    rpt_fire     = 1'b0;
    rpt_cnt_next = rpt_cnt + RW'(1);
    if (!repeat_en || fall || state == IDLE) begin
      rpt_cnt_next = '0;
    end else if (state == HOLD && rpt_cnt == DLY_LAST) begin
      rpt_fire     = 1'b1;
      rpt_cnt_next = '0;
    end else if (state == REPEAT && rpt_cnt == PER_LAST) begin
      rpt_fire     = 1'b1;
      rpt_cnt_next = '0;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - N independent debounced keys with press/release/repeat pulses
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input logic           clk,
  input logic           reset_n,
  key_debouncer_if.slave bus
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_one #(
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_in      (bus.key_in[i]),
      .repeat_en   (bus.repeat_en),
      .key_down    (bus.key_down[i]),
      .key_press   (bus.key_press[i]),
      .key_release (bus.key_release[i]),
      .key_repeat  (bus.key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking bench for key_debouncer
module tb_key_debouncer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  key_debouncer_if #(.N_KEYS(2)) bus ();

  key_debouncer #(
    .N_KEYS          (2),
    .KEY_ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [1:0] kin;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      tag;
    int         idx;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;

  wire [7:0] act = {bus.key_repeat, bus.key_release, bus.key_press, bus.key_down};

  function automatic logic [7:0] mk(logic [1:0] dn, logic [1:0] pr, logic [1:0] rl, logic [1:0] rp);
    return {rp, rl, pr, dn};
  endfunction

  function automatic logic [1:0] k0(bit c);
    return {1'b0, c};
  endfunction

  function automatic logic [1:0] k1(bit c);
    return {c, 1'b0};
  endfunction

  function automatic logic [1:0] kb(bit c);
    return {c, c};
  endfunction

  task automatic check_now(string tag, int idx, logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got rpt/rel/prs/dn=%b want=%b", tag, idx, act, want);
    end
  endtask

  task automatic tick(string tag, int idx, logic [1:0] kin, logic en, logic [7:0] exp);
    sb_t e;
    bus.key_in    = kin;
    bus.repeat_en = en;
    sb_q.push_back('{tag, idx, exp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_now(e.tag, e.idx, e.exp);
  endtask

  initial begin
    // Vector table: idle, sub-threshold glitches, simultaneous press and release.
    for (int i = 0; i < 20; i++) tbl.push_back('{2'b11, 1'b0, 8'h00});
    for (int i = 0; i < 3; i++)  tbl.push_back('{2'b10, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 1'b0, 8'h00});
    for (int i = 0; i < 3; i++)  tbl.push_back('{2'b10, 1'b0, 8'h00});
    for (int i = 0; i < 10; i++) tbl.push_back('{2'b11, 1'b0, 8'h00});
    for (int t = 1; t <= 8; t++)
      tbl.push_back('{2'b00, 1'b0, mk(kb(t >= 6), kb(t == 6), 2'b00, 2'b00)});
    for (int t = 1; t <= 8; t++)
      tbl.push_back('{2'b11, 1'b0, mk(kb(t < 6), 2'b00, kb(t == 6), 2'b00)});

    reset_n       = 1'b0;
    bus.key_in    = 2'b11;
    bus.repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset", 0, 8'h00);
    reset_n = 1'b1;

    foreach (tbl[i]) tick("table", i, tbl[i].kin, tbl[i].en, tbl[i].exp);

    // Key 0 held with repeat; release edge lands on an expiring repeat count (g=37).
    for (int g = 1; g <= 47; g++)
      tick("hold_rel", g, (g <= 31) ? 2'b10 : 2'b11, 1'b1,
           mk(k0(g >= 6 && g < 37), k0(g == 6), k0(g == 37),
              k0(g >= 16 && g < 37 && (g - 16) % 3 == 0)));

    // Both keys pressed together; key 1 released while key 0 keeps repeating.
    for (int g = 1; g <= 40; g++)
      tick("two_key", g, (g <= 12) ? 2'b00 : 2'b10, 1'b1,
           mk({g >= 6 && g < 18, g >= 6}, kb(g == 6), k1(g == 18),
              {g == 16, g >= 16 && (g - 16) % 3 == 0}));

    // Asynchronous reset mid-repeat with key 0 still held.
    reset_n = 1'b0;
    #2;
    check_now("async_rst", 0, 8'h00);
    @(posedge clk);
    #1;
    check_now("async_rst", 1, 8'h00);
    reset_n = 1'b1;

    for (int g = 1; g <= 60; g++)
      tick("no_rpt", g, 2'b10, 1'b0, mk(k0(g >= 6), k0(g == 6), 2'b00, 2'b00));

    // Re-enable while held: full delay restarts from the enable.
    for (int h = 1; h <= 20; h++)
      tick("re_en", h, 2'b10, 1'b1,
           mk(2'b01, 2'b00, 2'b00, k0(h >= 10 && (h - 10) % 3 == 0)));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard left=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
